// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin arbiter for the single-outstanding
// bus (bus_en / wr_rd / wr_data / addr / size / ack / rd_data).
//
// One master request is accepted per transaction. It is latched into the
// slave-side registers, and o_bus_en is held high until the slave acks or a
// watchdog fires. The owner then gets a one-cycle ack with the captured read
// data and an error flag.
//
// Ports
//   i_clk, i_rst         clock (rising edge), async reset (active low)
//   i_mX_bus_en/wr_rd/wr_data/addr/size   master X request, held until ack
//   o_mX_ack/rd_data/err                  master X one-cycle response
//   o_bus_en/wr_rd/wr_data/addr/size      slave-side request
//   i_ack, i_rd_data                      slave completion and read data
//
// Parameters
//   TIMEOUT  BUSY cycles without i_ack before abort (1 .. 2^CNT_W-1)
//   CNT_W    watchdog counter width

// Response gating for one master. Ack, data and err are only non-zero while
// this master owns the RESP cycle.
module bus_arbiter_rr_port (
  input  logic        i_sel,
  input  logic [31:0] i_rd_data,
  input  logic        i_err,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_err
);
  assign o_ack     = i_sel;
  assign o_rd_data = i_sel ? i_rd_data : '0;
  assign o_err     = i_sel & i_err;
endmodule

module bus_arbiter_rr #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_bus_en,
  input  logic        i_m0_wr_rd,
  input  logic [31:0] i_m0_wr_data,
  input  logic [31:0] i_m0_addr,
  input  logic [2:0]  i_m0_size,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_rd_data,
  output logic        o_m0_err,
  input  logic        i_m1_bus_en,
  input  logic        i_m1_wr_rd,
  input  logic [31:0] i_m1_wr_data,
  input  logic [31:0] i_m1_addr,
  input  logic [2:0]  i_m1_size,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_rd_data,
  output logic        o_m1_err,
  output logic        o_bus_en,
  output logic        o_wr_rd,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_addr,
  output logic [2:0]  o_size,
  input  logic        i_ack,
  input  logic [31:0] i_rd_data
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rsp_data;
  logic             rsp_err;

  logic [1:0] req;
  logic       gnt;
  logic       sel_wr_rd;
  logic [31:0] sel_wr_data;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;

  assign req = {i_m1_bus_en, i_m0_bus_en};

  // Tie goes to the master that did not win last; otherwise the lone
  // requester wins. Value is irrelevant when nobody requests.
  always_comb begin
    gnt = ~req[0];
    if (&req) gnt = ~last_grant;
  end

  always_comb begin
    sel_wr_rd   = gnt ? i_m1_wr_rd   : i_m0_wr_rd;
    sel_wr_data = gnt ? i_m1_wr_data : i_m0_wr_data;
    sel_addr    = gnt ? i_m1_addr    : i_m0_addr;
    sel_size    = gnt ? i_m1_size    : i_m0_size;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      o_wr_rd    <= 1'b0;
      o_wr_data  <= '0;
      o_addr     <= '0;
      o_size     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner      <= gnt;
            last_grant <= gnt;
            o_wr_rd    <= sel_wr_rd;
            o_wr_data  <= sel_wr_data;
            o_addr     <= sel_addr;
            o_size     <= sel_size;
            cnt        <= '0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // Ack is checked first so it wins over a same-cycle timeout.
          if (i_ack) begin
            rsp_data <= o_wr_rd ? 32'd0 : i_rd_data;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (cnt == TO_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_en = (state == S_BUSY);

  logic [1:0]       p_ack;
  logic [1:0]       p_err;
  logic [1:0][31:0] p_rd;

  for (genvar g = 0; g < 2; g++) begin : g_port
    bus_arbiter_rr_port u_port (
      .i_sel     ((state == S_RESP) && (owner == 1'(g))),
      .i_rd_data (rsp_data),
      .i_err     (rsp_err),
      .o_ack     (p_ack[g]),
      .o_rd_data (p_rd[g]),
      .o_err     (p_err[g])
    );
  end

  assign o_m0_ack     = p_ack[0];
  assign o_m0_rd_data = p_rd[0];
  assign o_m0_err     = p_err[0];
  assign o_m1_ack     = p_ack[1];
  assign o_m1_rd_data = p_rd[1];
  assign o_m1_err     = p_err[1];
endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;
  localparam int TIMEOUT = 6;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        m_en[2];
  logic        m_wr[2];
  logic [31:0] m_wd[2];
  logic [31:0] m_addr[2];
  logic [2:0]  m_size[2];
  logic        ack_o[2];
  logic [31:0] rd_o[2];
  logic        err_o[2];
  logic        o_bus_en, o_wr_rd;
  logic [31:0] o_wr_data, o_addr;
  logic [2:0]  o_size;
  logic        i_ack;
  logic [31:0] i_rd_data;

  int total = 0;
  int bad   = 0;
  int last  = 1;   // model: master that won the previous grant

  always #5 i_clk = ~i_clk;

  bus_arbiter_rr #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_bus_en(m_en[0]), .i_m0_wr_rd(m_wr[0]), .i_m0_wr_data(m_wd[0]),
    .i_m0_addr(m_addr[0]), .i_m0_size(m_size[0]),
    .o_m0_ack(ack_o[0]), .o_m0_rd_data(rd_o[0]), .o_m0_err(err_o[0]),
    .i_m1_bus_en(m_en[1]), .i_m1_wr_rd(m_wr[1]), .i_m1_wr_data(m_wd[1]),
    .i_m1_addr(m_addr[1]), .i_m1_size(m_size[1]),
    .o_m1_ack(ack_o[1]), .o_m1_rd_data(rd_o[1]), .o_m1_err(err_o[1]),
    .o_bus_en(o_bus_en), .o_wr_rd(o_wr_rd), .o_wr_data(o_wr_data),
    .o_addr(o_addr), .o_size(o_size),
    .i_ack(i_ack), .i_rd_data(i_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Round-robin rule: a tie goes to the master that did not win last time.
  function automatic int pick(input logic r0, input logic r1, input int prev);
    if (r0 && r1) return 1 - prev;
    return r0 ? 0 : 1;
  endfunction

  task automatic new_req(input int j);
    m_en[j]   = 1'b1;
    m_wr[j]   = 1'($urandom % 2);
    m_wd[j]   = $urandom;
    m_addr[j] = $urandom;
    m_size[j] = 3'($urandom % 8);
  endtask

  task automatic set_req(input int j, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    m_en[j] = 1'b1; m_wr[j] = wr; m_addr[j] = a; m_wd[j] = d; m_size[j] = s;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".bus_en"}, 32'(o_bus_en), 32'd0);
    chk({tag, ".ack0"}, 32'(ack_o[0]), 32'd0);
    chk({tag, ".ack1"}, 32'(ack_o[1]), 32'd0);
  endtask

  // Called in an IDLE cycle with requests already driven. k = bus_en cycle on
  // which the slave acks (1-based); k outside 1..TIMEOUT means no ack.
  // Returns the granted master and leaves the DUT in the next IDLE cycle.
  task automatic txn(input logic [31:0] sd, input int k, input bit rereq, output int w);
    logic [31:0] ea, ed, erd;
    logic [2:0]  es;
    logic        ew, ok;
    int          o;
    w  = pick(m_en[0], m_en[1], last);
    o  = 1 - w;
    ea = m_addr[w]; ed = m_wd[w]; es = m_size[w]; ew = m_wr[w];
    i_ack = 1'($urandom % 2);           // ignored in IDLE
    i_rd_data = $urandom;
    tick();
    for (int c = 1; c <= TIMEOUT; c++) begin
      chk("busy.bus_en", 32'(o_bus_en), 32'd1);
      chk("busy.addr", o_addr, ea);
      chk("busy.wdata", o_wr_data, ed);
      chk("busy.size", 32'(o_size), 32'(es));
      chk("busy.wr_rd", 32'(o_wr_rd), 32'(ew));
      chk("busy.ack_any", 32'(ack_o[0] | ack_o[1]), 32'd0);
      i_ack     = (c == k);
      i_rd_data = (c == k) ? sd : $urandom;
      tick();
      if (c == k) break;
    end
    ok  = (k >= 1 && k <= TIMEOUT);
    erd = (ok && !ew) ? sd : 32'd0;
    i_ack = 1'($urandom % 2);           // ignored in RESP
    i_rd_data = $urandom;
    chk("resp.bus_en", 32'(o_bus_en), 32'd0);
    chk("resp.addr_hold", o_addr, ea);
    chk("resp.ack", 32'(ack_o[w]), 32'd1);
    chk("resp.rd_data", rd_o[w], erd);
    chk("resp.err", 32'(err_o[w]), 32'(!ok));
    chk("resp.other_ack", 32'(ack_o[o]), 32'd0);
    chk("resp.other_rd", rd_o[o], 32'd0);
    chk("resp.other_err", 32'(err_o[o]), 32'd0);
    last = w;
    if (rereq) new_req(w);
    else m_en[w] = 1'b0;
    tick();
    i_ack = 1'b0;
    idle_chk("idle");
    chk("idle.rd0", rd_o[0], 32'd0);
    chk("idle.err1", 32'(err_o[1]), 32'd0);
  endtask

  initial begin
    int w;
    i_rst = 1'b0; i_ack = 1'b0; i_rd_data = '0;
    for (int j = 0; j < 2; j++) begin
      m_en[j] = 0; m_wr[j] = 0; m_wd[j] = '0; m_addr[j] = '0; m_size[j] = '0;
    end
    #1;
    idle_chk("reset");
    chk("reset.addr", o_addr, 32'd0);
    chk("reset.wdata", o_wr_data, 32'd0);
    tick(); tick();
    i_rst = 1'b1;
    last  = 1;

    // m0 read, slave acks on first bus cycle
    set_req(0, 1'b0, 32'h0000_1000, 32'h0, 3'd2);
    txn(32'hDEAD_BEEF, 1, 1'b0, w);
    chk("t1.winner", 32'(w), 32'd0);

    // m1 write, slave acks after 5 bus cycles, read data must come back 0
    set_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'd0);
    txn(32'hCAFE_F00D, 5, 1'b0, w);
    chk("t2.winner", 32'(w), 32'd1);

    // both masters keep requesting: strict alternation
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      txn($urandom, 1 + int'($urandom % 3), (i < 3), w);
      chk("fair.winner", 32'(w), 32'(i % 2));
    end

    // m0 still pending; slave never acks -> timeout error
    m_wr[0] = 1'b0;
    txn(32'h5555_AAAA, 0, 1'b0, w);
    chk("to.winner", 32'(w), 32'd0);
    new_req(1);
    txn(32'h0BAD_F00D, 2, 1'b0, w);
    chk("to.next_m1", 32'(w), 32'd1);

    // ack on the exact timeout cycle wins
    set_req(0, 1'b0, 32'h0000_4444, 32'h0, 3'd2);
    txn(32'h7777_1234, TIMEOUT, 1'b0, w);

    // reset mid-BUSY with both requesting: no ack, m0 wins afterwards
    new_req(0); new_req(1);
    m_wr[0] = 1'b0;
    tick();
    chk("rst.busy", 32'(o_bus_en), 32'd1);
    i_rst = 1'b0;
    #1;
    idle_chk("rst.async");
    chk("rst.addr", o_addr, 32'd0);
    tick();
    idle_chk("rst.held");
    i_rst = 1'b1;
    last  = 1;
    txn(32'h0102_0304, 2, 1'b0, w);
    chk("rst.winner", 32'(w), 32'd0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 2; j++)
        if (!m_en[j] && ($urandom % 2) == 1) new_req(j);
      if (!m_en[0] && !m_en[1]) new_req(int'($urandom % 2));
      txn($urandom, int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom % 2), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
